// File: rtl/input_debounce_if.sv
// input_debounce_if: raw input, debounced level and edge-pulse bundle for input_debounce
// Ports: raw_i (to debouncer), db_o/rise_o/fall_o (from debouncer);
//   with DEBOUNCE_CAPTURE_EN defined also cap_clr_i (to), edge_cap_o/irq_o (from).
interface input_debounce_if #(parameter int WIDTH = 5);
  logic [WIDTH-1:0] raw_i;
  logic [WIDTH-1:0] db_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
`ifdef DEBOUNCE_CAPTURE_EN
  logic [WIDTH-1:0] cap_clr_i;
  logic [WIDTH-1:0] edge_cap_o;
  logic             irq_o;
  modport master (output raw_i, cap_clr_i, input db_o, rise_o, fall_o, edge_cap_o, irq_o);
  modport slave  (input raw_i, cap_clr_i, output db_o, rise_o, fall_o, edge_cap_o, irq_o);
`else
  modport master (output raw_i, input db_o, rise_o, fall_o);
  modport slave  (input raw_i, output db_o, rise_o, fall_o);
`endif
endinterface

// File: rtl/input_debounce.sv
// input_debounce: per-channel 2-flop synchroniser and stability-counter debouncer with edge pulses
// Ports: clk; reset_n (synchronous, active-low); bus (input_debounce_if.slave):
//   raw_i in, db_o/rise_o/fall_o out; with DEBOUNCE_CAPTURE_EN defined also
//   cap_clr_i in, edge_cap_o (sticky rise capture) and irq_o out.
module input_debounce #(
  parameter int               WIDTH         = 5,
  parameter int               STABLE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_VAL     = 5'b10000,
  parameter logic [WIDTH-1:0] INVERT_MASK   = 5'b10000
) (
  input logic             clk,
  input logic             reset_n,
  input_debounce_if.slave bus
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d, hit, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  always_comb begin
    hit = '0;
    cnt_d = cnt_q;
    for (int k = 0; k < WIDTH; k++) begin
      hit[k] = sync2_q[k] != stable_q[k] && cnt_q[k] == LAST;
      cnt_d[k] = (sync2_q[k] == stable_q[k] || hit[k]) ? '0 : cnt_q[k] + 1'b1;
    end
    stable_d = stable_q ^ hit;
    rise_d = hit & (stable_d ^ INVERT_MASK);
    fall_d = hit & ~(stable_d ^ INVERT_MASK);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      stable_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      sync1_q <= bus.raw_i;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.db_o = stable_q ^ INVERT_MASK;
  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;
`ifdef DEBOUNCE_CAPTURE_EN
  // Capture follows the visible rise_o, so a clear in the pulse cycle loses to the set.
  logic [WIDTH-1:0] cap_q, cap_d;
  always_comb cap_d = rise_q | (cap_q & ~bus.cap_clr_i);
  always_ff @(posedge clk) begin
    if (!reset_n) cap_q <= '0;
    else cap_q <= cap_d;
  end
  assign bus.edge_cap_o = cap_q;
  assign bus.irq_o = |cap_q;
`endif
endmodule
